// File: rtl/lifo_pkg.sv
// lifo_pkg: shared helpers for the parametrised LIFO stack.
//   cnt_width() - width of a counter that holds 0..depth inclusive
//   QEmptyBit   - fill bit of the q output when the stack is empty
package lifo_pkg;

    // Wide enough to hold the value DEPTH itself, not just DEPTH-1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // The q output is replicated from this bit when the stack holds nothing.
    localparam bit QEmptyBit = 1'b0;

endpackage

// File: rtl/lifo_storage.sv
// lifo_storage: DEPTH x WIDTH register array, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
// Ports:
//   clock       rising-edge clock
//   we          write enable
//   waddr/wdata write address / data
//   raddr       read address
//   rdata       combinational read data at raddr
module lifo_storage import lifo_pkg::*; #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with push, pop, single-cycle replace
// (push+pop), registered top-of-stack peek and sticky error flags.
// Optional: define LIFO_HWM_EN to add the hwm (high-water mark) output.
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   data/push/pop    word to push, push request, pop request
//   err_clr          synchronous clear of overflow/underflow (and reload of hwm)
//   q                registered top of stack, 0 when empty
//   count            registered number of stored entries, 0..DEPTH
//   empty/full       registered count==0 / count==DEPTH
//   overflow         sticky: a push was rejected
//   underflow        sticky: a pop was rejected
//   hwm              (LIFO_HWM_EN only) maximum count since reset or err_clr
module lifo_stack import lifo_pkg::*; #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
`ifdef LIFO_HWM_EN
    ,
    output logic [CW-1:0]    hwm
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             empty_q, full_q, ovf_q, unf_q;
    logic             wr, rd;
    logic [AW-1:0]    waddr, raddr;
    logic [WIDTH-1:0] rdata;

    // Acceptance on pre-edge state; a replace on a full stack is legal.
    always_comb begin
        rd = pop && (count_q != '0);
        wr = push && ((count_q < CW'(DEPTH)) || rd);
    end

    always_comb begin
        count_d = count_q;
        if (wr && !rd) begin
            count_d = count_q + CW'(1);
        end else if (rd && !wr) begin
            count_d = count_q - CW'(1);
        end
    end

    // Replace overwrites the current top; a plain push writes one above it.
    // The read address is only consumed on a plain pop with count>=2.
    always_comb begin
        waddr = rd ? AW'(count_q - CW'(1)) : AW'(count_q);
        raddr = AW'(count_q - CW'(2));
    end

    always_comb begin
        q_d = q_q;
        if (wr) begin
            q_d = data;
        end else if (rd) begin
            q_d = (count_d == '0) ? {WIDTH{QEmptyBit}} : rdata;
        end
    end

    lifo_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clock (clock),
        .we    (wr),
        .waddr (waddr),
        .wdata (data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            q_q     <= {WIDTH{QEmptyBit}};
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            q_q     <= q_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
            // A new rejection wins over a same-cycle clear.
            ovf_q   <= (push && !wr) || (ovf_q && !err_clr);
            unf_q   <= (pop && !rd) || (unf_q && !err_clr);
        end
    end

`ifdef LIFO_HWM_EN
    logic [CW-1:0] hwm_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hwm_q <= '0;
        end else if (err_clr) begin
            hwm_q <= count_d;
        end else if (count_d > hwm_q) begin
            hwm_q <= count_d;
        end
    end

    assign hwm = hwm_q;
`endif

    assign q         = q_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] data;
    logic             push, pop, err_clr;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    count;
    logic             empty, full, overflow, underflow;
`ifdef LIFO_HWM_EN
    logic [CW-1:0]    hwm;
`endif

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .data      (data),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .q         (q),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef LIFO_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [CW-1:0]    count;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             unf;
        logic [CW-1:0]    hwm;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] stk[$];
    logic             m_ovf, m_unf;
    int unsigned      m_hwm;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_hwm = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_q"}, 32'(q), 32'h0);
        check_val({tag, "_count"}, 32'(count), 32'h0);
        check_val({tag, "_empty"}, 32'(empty), 32'h1);
        check_val({tag, "_full"}, 32'(full), 32'h0);
        check_val({tag, "_ovf"}, 32'(overflow), 32'h0);
        check_val({tag, "_unf"}, 32'(underflow), 32'h0);
`ifdef LIFO_HWM_EN
        check_val({tag, "_hwm"}, 32'(hwm), 32'h0);
`endif
    endtask

    // Drive one cycle of stimulus, push the model's expectation onto the
    // scoreboard, then pop and compare it just after the edge.
    task automatic do_op(input string tag, input logic p, input logic o, input logic c,
                         input logic [WIDTH-1:0] d);
        exp_t e;
        int   n;
        logic w, r;
        @(negedge clock);
        push = p; pop = o; err_clr = c; data = d;
        n = stk.size();
        r = o && (n > 0);
        w = p && ((n < int'(DEPTH)) || r);
        if (w && r)  stk[n-1] = d;
        else if (w)  stk.push_back(d);
        else if (r)  void'(stk.pop_back());
        m_ovf = (p && !w) || (m_ovf && !c);
        m_unf = (o && !r) || (m_unf && !c);
        if (c)                       m_hwm = stk.size();
        else if (stk.size() > m_hwm) m_hwm = stk.size();
        e.q     = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        e.count = CW'(stk.size());
        e.empty = (stk.size() == 0);
        e.full  = (stk.size() == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.hwm   = CW'(m_hwm);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        e = exp_q.pop_front();
        check_val({tag, "_q"}, 32'(q), 32'(e.q));
        check_val({tag, "_count"}, 32'(count), 32'(e.count));
        check_val({tag, "_empty"}, 32'(empty), 32'(e.empty));
        check_val({tag, "_full"}, 32'(full), 32'(e.full));
        check_val({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
        check_val({tag, "_unf"}, 32'(underflow), 32'(e.unf));
`ifdef LIFO_HWM_EN
        check_val({tag, "_hwm"}, 32'(hwm), 32'(e.hwm));
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; data = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        @(negedge clock);
        reset_n = 1'b1;

        // Basic push/pop ordering.
        do_op("push1", 1, 0, 0, 16'h1111);
        do_op("push2", 1, 0, 0, 16'h2222);
        do_op("push3", 1, 0, 0, 16'h3333);
        do_op("pop1", 0, 1, 0, '0);
        do_op("pop2", 0, 1, 0, '0);
        do_op("pop3", 0, 1, 0, '0);

        // Fill past DEPTH: fifth push rejected.
        do_op("fillA", 1, 0, 0, 16'h000A);
        do_op("fillB", 1, 0, 0, 16'h000B);
        do_op("fillC", 1, 0, 0, 16'h000C);
        do_op("fillD", 1, 0, 0, 16'h000D);
        do_op("fillE", 1, 0, 0, 16'h000E);
        do_op("ovfclr", 0, 0, 1, '0);
        repeat (4) do_op("drain", 0, 1, 0, '0);

        // Replace in the middle of the stack.
        do_op("mid99", 1, 0, 0, 16'h0099);
        do_op("midAA", 1, 0, 0, 16'h00AA);
        do_op("replBB", 1, 1, 0, 16'h00BB);
        do_op("popBB", 0, 1, 0, '0);
        do_op("pop99", 0, 1, 0, '0);

        // Underflow and push+pop on empty.
        do_op("unf", 0, 1, 0, '0);
        do_op("pp_empty", 1, 1, 0, 16'h5A5A);
        do_op("pop5A", 0, 1, 0, '0);
        do_op("clr_vs_unf", 0, 1, 1, '0);
        do_op("unfclr", 0, 0, 1, '0);

        // Replace on a full stack is legal.
        do_op("f1", 1, 0, 0, 16'h0101);
        do_op("f2", 1, 0, 0, 16'h0202);
        do_op("f3", 1, 0, 0, 16'h0303);
        do_op("f4", 1, 0, 0, 16'h0404);
        do_op("repl_full", 1, 1, 0, 16'h7777);

        // Asynchronous reset between edges.
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // High-water mark sequence (also checks the stack restarts empty).
        do_op("h_push1", 1, 0, 0, 16'hC001);
        do_op("h_push2", 1, 0, 0, 16'hC002);
        do_op("h_push3", 1, 0, 0, 16'hC003);
        do_op("h_pop1", 0, 1, 0, '0);
        do_op("h_pop2", 0, 1, 0, '0);
        do_op("h_push4", 1, 0, 0, 16'hC004);
        do_op("h_clr", 0, 0, 1, '0);

        // Random mix.
        for (int i = 0; i < 60; i++) begin
            do_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 16'($urandom));
        end

        check_val("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
